fixed_to_float_signed_round: RTL and testbench
==============================================

// Module: fixed_to_float_signed_round
// PURPOSE
//  Pipelined normalizer/rounder: signed two's-complement fixed-point word (accumulator output) -> FloatSigned fields.
//  Output is already rounded to FRAC bits, so it feeds the linear->log converter (EXP_IN=EXP, FRAC_IN=FRAC) directly.
//  Sits between the linear accumulator drain and the log conversion stage; valid/ready on both sides.
// PARAMETERS
//  ACC_WIDTH  24  input width, two's complement
//  ACC_FRAC   8   fractional bits of input (value = acc * 2^-ACC_FRAC)
//  EXP        8   output signed exponent width
//  FRAC       4   output fraction width (hidden leading 1 implied)
// PORTS
//  clock      in   1          sole clock, all state on posedge
//  resetn     in   1          synchronous, active-low reset
//  in_valid   in   1          input word present
//  in_ready   out  1          stage can accept input this cycle
//  in_acc     in   ACC_WIDTH  signed fixed-point input
//  out_valid  out  1          output fields valid
//  out_ready  in   1          downstream accepts output
//  out_sign   out  1          1 = negative
//  out_exp    out  EXP        signed unbiased exponent
//  out_frac   out  FRAC       fraction below hidden 1
//  out_isZero out  1          value is zero (incl. underflow)
//  out_isInf  out  1          exponent overflow
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): both stage valids and out_valid=0; out_sign/exp/frac/isZero/isInf=0. in_ready=1 the cycle after.
//  - Stage 1 (S1) registers sign=in_acc[MSB] and magnitude |in_acc| in ACC_WIDTH unsigned bits (-2^(ACC_WIDTH-1) is representable).
//  - Stage 2 (S2 = output regs): leading-one detect p on magnitude; e = p - ACC_FRAC; left-normalize; keep FRAC bits below the leading one;
//    guard = next bit, sticky = OR of remaining bits; round per CONFIGURATION.
//  - Rounding carry out of the fraction: frac=0, e=e+1; overflow checked after carry.
//  - Exponent arithmetic in max(EXP, clog2(ACC_WIDTH)+2) signed bits, then:
//    e > 2^(EXP-1)-1 -> isInf=1, frac=0, exp=0, sign kept;
//    e < -2^(EXP-1) -> isZero=1, sign=0, exp=0, frac=0;
//    magnitude 0 -> isZero=1, sign=0, exp=0, frac=0.
//  - Latency: 2 cycles in_valid&in_ready -> out_valid with no backpressure; throughput 1 word/cycle.
//  - Handshake: transfer on valid&ready at either side.
//    Pipeline advances when S2 empty or out_ready=1; S1 loads when S1 empty or S1 advances.
//    in_ready = !s1_valid | !out_valid | out_ready (combinational, no in->out comb path except through ready).
//  - While out_valid=1 and out_ready=0, all out_* held stable; no word dropped or duplicated.
//  - Simultaneous accept and drain in the same cycle is allowed at both stages (full throughput under out_ready=1).
//  - resetn low mid-stream discards all in-flight words; nothing emitted for them.
//  - in_acc ignored when in_valid=0; X on in_acc with in_valid=0 must not propagate.
// CONFIGURATION
//  FIXED_TO_FLOAT_RNE_EN defined: round-to-nearest-even; round up when guard & (sticky | frac_lsb).
//  Not defined: truncate toward zero (guard/sticky discarded); frac carry and post-carry overflow cannot occur.
//  Latency, handshake, zero/inf handling identical in both builds.
// TESTING (ACC_WIDTH=16, ACC_FRAC=8, EXP=8, FRAC=4 unless stated; RNE build unless stated)
//  acc=0x0100 (1.0) -> 2 cycles later sign=0 exp=0 frac=0x0 isZero=0 isInf=0; acc=0xFF00 -> same with sign=1.
//  acc=0x0198 (1.10011b) -> exp=0 frac=0xA (RNE up); truncate build -> frac=0x9.
//  acc=0x0188 (tie, lsb 0) -> frac=0x8; acc=0x01F8 -> carry: exp=1 frac=0x0.
//  acc=0x0000 -> isZero=1 sign=0; acc=0x8000 -> sign=1 exp=7 frac=0x0.
//  EXP=3: acc=0x1000 (e=4) -> isInf=1; acc=0x0001 (e=-8) -> isZero=1; acc=0x0F80 (RNE to 16.0) -> isInf=1.
//  Stream 64 random words, out_ready toggled randomly and held low 5 cycles mid-burst:
//    outputs in order, stable while stalled, match model; resetn pulse mid-burst -> out_valid=0 next cycle, in-flight words dropped.

Source files
------------

// File: rtl/fixed_to_float_signed_round.sv
// rtl/fixed_to_float_signed_round.sv - two-stage signed fixed-point to sign/exponent/fraction normalizer
//
// Converts a signed two's-complement accumulator word into sign, unbiased exponent
// and a FRAC-bit fraction below an implied leading one. Stage 1 registers sign and
// magnitude. Stage 2 (the output registers) normalizes, rounds and classifies.
//
// Build option: FIXED_TO_FLOAT_RNE_EN
//   defined   -> round to nearest, ties to even
//   undefined -> truncate toward zero
//
// Ports:
//   clock, resetn          clock and synchronous active-low reset
//   in_valid/in_ready      input handshake; in_acc is the signed input word
//   out_valid/out_ready    output handshake
//   out_sign, out_exp      sign (1 = negative), signed unbiased exponent
//   out_frac               fraction bits below the hidden one
//   out_isZero, out_isInf  zero/underflow flag, exponent overflow flag
module fixed_to_float_signed_round #(
  parameter int ACC_WIDTH = 24,
  parameter int ACC_FRAC  = 8,
  parameter int EXP       = 8,
  parameter int FRAC      = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP-1:0]       out_exp,
  output logic [FRAC-1:0]      out_frac,
  output logic                 out_isZero,
  output logic                 out_isInf
);

  localparam int PW = $clog2(ACC_WIDTH);
  localparam int EW = (EXP > PW + 2) ? EXP : PW + 2;
  // guard bit index inside the normalized word; bits below it form sticky
  localparam int SB = ACC_WIDTH - 2 - FRAC;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(-(1 << (EXP - 1)));

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [ACC_WIDTH-1:0] r_s1_mag;

  logic                 r_out_valid;
  logic                 r_out_sign;
  logic [EXP-1:0]       r_out_exp;
  logic [FRAC-1:0]      r_out_frac;
  logic                 r_out_zero;
  logic                 r_out_inf;

  logic                 w_advance;
  logic [PW-1:0]        w_p;
  logic [ACC_WIDTH-1:0] w_norm;
  logic [FRAC-1:0]      w_frac_t;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_round_up;
  logic [FRAC:0]        w_sum;
  logic signed [EW-1:0] w_e;
  logic                 w_sign_n;
  logic [EXP-1:0]       w_exp_n;
  logic [FRAC-1:0]      w_frac_n;
  logic                 w_zero_n;
  logic                 w_inf_n;

  // Output stage moves whenever it is empty or being drained.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_acc[ACC_WIDTH-1];
        // -2^(W-1) maps to 2^(W-1), which still fits unsigned W bits
        r_s1_mag  <= in_acc[ACC_WIDTH-1] ? (~in_acc + 1'b1) : in_acc;
      end
    end
  end

  // Leading-one position (highest set bit wins).
  always_comb begin
    w_p = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (r_s1_mag[i]) w_p = PW'(i);
    end
  end

  assign w_norm   = r_s1_mag << (PW'(ACC_WIDTH - 1) - w_p);
  assign w_frac_t = w_norm[ACC_WIDTH-2 -: FRAC];
  assign w_guard  = w_norm[SB];
  assign w_sticky = |w_norm[SB-1:0];

`ifdef FIXED_TO_FLOAT_RNE_EN
  assign w_round_up = w_guard & (w_sticky | w_frac_t[0]);
`else
  // truncation: guard and sticky are discarded
  assign w_round_up = 1'b0 & w_guard & w_sticky;
`endif

  assign w_sum = {1'b0, w_frac_t} + {{FRAC{1'b0}}, w_round_up};
  // a fraction carry bumps the exponent; the fraction bits are already zero then
  assign w_e   = EW'(w_p) - EW'(ACC_FRAC) + EW'(w_sum[FRAC]);

  always_comb begin
    w_sign_n = 1'b0;
    w_exp_n  = '0;
    w_frac_n = '0;
    w_zero_n = 1'b0;
    w_inf_n  = 1'b0;
    // normalized MSB is clear only when the magnitude is zero
    if (!w_norm[ACC_WIDTH-1]) begin
      w_zero_n = 1'b1;
    end else if (w_e > E_MAX) begin
      w_inf_n  = 1'b1;
      w_sign_n = r_s1_sign;
    end else if (w_e < E_MIN) begin
      w_zero_n = 1'b1;
    end else begin
      w_sign_n = r_s1_sign;
      w_exp_n  = w_e[EXP-1:0];
      w_frac_n = w_sum[FRAC-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_frac  <= '0;
      r_out_zero  <= 1'b0;
      r_out_inf   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sign <= w_sign_n;
        r_out_exp  <= w_exp_n;
        r_out_frac <= w_frac_n;
        r_out_zero <= w_zero_n;
        r_out_inf  <= w_inf_n;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sign   = r_out_sign;
  assign out_exp    = r_out_exp;
  assign out_frac   = r_out_frac;
  assign out_isZero = r_out_zero;
  assign out_isInf  = r_out_inf;

endmodule

// File: tb/tb_fixed_to_float_signed_round.sv
// tb/tb_fixed_to_float_signed_round.sv - self-checking bench for fixed_to_float_signed_round
module tb_fixed_to_float_signed_round;

`ifdef FIXED_TO_FLOAT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [3:0] f;
    logic       z;
    logic       i;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    res_t        r;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_acc = '0;

  logic        a_in_ready, a_valid, a_sign, a_zero, a_inf;
  logic [7:0]  a_exp;
  logic [3:0]  a_frac;
  logic        b_in_ready, b_valid, b_sign, b_zero, b_inf;
  logic [2:0]  b_exp;
  logic [3:0]  b_frac;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fixed_to_float_signed_round #(.ACC_WIDTH(16), .ACC_FRAC(8), .EXP(8), .FRAC(4)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_acc(in_acc), .out_valid(a_valid), .out_ready(out_ready), .out_sign(a_sign),
    .out_exp(a_exp), .out_frac(a_frac), .out_isZero(a_zero), .out_isInf(a_inf));

  fixed_to_float_signed_round #(.ACC_WIDTH(16), .ACC_FRAC(8), .EXP(3), .FRAC(4)) dut3 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_acc(in_acc), .out_valid(b_valid), .out_ready(out_ready), .out_sign(b_sign),
    .out_exp(b_exp), .out_frac(b_frac), .out_isZero(b_zero), .out_isInf(b_inf));

  // Reference: value = acc/256; scale magnitude so the quotient carries the hidden one
  // plus four fraction bits, round on the exact remainder, then range-check the exponent.
  function automatic res_t model(input logic [15:0] acc, input int expw);
    res_t   r;
    longint a, m, num, den, q, rem;
    int     p, e, emax;
    r = '0;
    a = longint'($signed(acc));
    m = (a < 0) ? -a : a;
    if (m == 0) begin
      r.z = 1'b1;
      return r;
    end
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    num = m << 4;
    den = longint'(1) << p;
    q   = num / den;
    rem = num % den;
    if (RNE && ((2 * rem > den) || ((2 * rem == den) && q[0]))) q++;
    e = p - 8;
    if (q == 32) begin
      q = 16;
      e++;
    end
    emax = (1 << (expw - 1)) - 1;
    if (e > emax) begin
      r.s = (a < 0);
      r.i = 1'b1;
    end else if (e < -emax - 1) begin
      r.z = 1'b1;
    end else begin
      r.s = (a < 0);
      r.e = 8'(e);
      r.f = 4'(q - 16);
    end
    return r;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b expected 0/0", a_valid, b_valid);
    end
    n_tests++;
    if ({a_sign, a_exp, a_frac, a_zero, a_inf} !== 15'd0) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 0", {a_sign, a_exp, a_frac, a_zero, a_inf});
    end
    resetn = 1'b1;
    @(negedge clock);
    n_tests++;
    if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got rdy=%b vld=%b expected rdy=1 vld=0", a_in_ready, a_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v[7];
    v[0] = '{16'h0100, '{1'b0, 8'd0, 4'h0, 1'b0, 1'b0}};
    v[1] = '{16'hFF00, '{1'b1, 8'd0, 4'h0, 1'b0, 1'b0}};
    v[2] = '{16'h0198, '{1'b0, 8'd0, (RNE ? 4'hA : 4'h9), 1'b0, 1'b0}};
    v[3] = '{16'h0188, '{1'b0, 8'd0, 4'h8, 1'b0, 1'b0}};
    v[4] = '{16'h01F8, '{1'b0, (RNE ? 8'd1 : 8'd0), (RNE ? 4'h0 : 4'hF), 1'b0, 1'b0}};
    v[5] = '{16'h0000, '{1'b0, 8'd0, 4'h0, 1'b1, 1'b0}};
    v[6] = '{16'h8000, '{1'b1, 8'd7, 4'h0, 1'b0, 1'b0}};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_acc = v[k].a;
      @(negedge clock);
      in_valid = 1'b0; in_acc = 'x;
      n_tests++;
      if (a_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir_latency acc=%h: got out_valid=%b after 1 cycle expected 0", v[k].a, a_valid);
      end
      @(negedge clock);
      n_tests++;
      if (a_valid !== 1'b1 || {a_sign, a_exp, a_frac, a_zero, a_inf} !== v[k].r) begin
        n_fail++;
        $display("FAIL dir acc=%h: got vld=%b fields=%h expected vld=1 fields=%h",
                 v[k].a, a_valid, {a_sign, a_exp, a_frac, a_zero, a_inf}, v[k].r);
      end
    end
  endtask

  task automatic test_exp3();
    vec_t v[6];
    v[0] = '{16'h1000, '{1'b0, 8'd0, 4'h0, 1'b0, 1'b1}};
    v[1] = '{16'h0001, '{1'b0, 8'd0, 4'h0, 1'b1, 1'b0}};
    v[2] = '{16'h0F80, (RNE ? res_t'{1'b0, 8'd0, 4'h0, 1'b0, 1'b1} : res_t'{1'b0, 8'd3, 4'hF, 1'b0, 1'b0})};
    v[3] = '{16'hF000, '{1'b1, 8'd0, 4'h0, 1'b0, 1'b1}};
    v[4] = '{16'h0800, '{1'b0, 8'd3, 4'h0, 1'b0, 1'b0}};
    v[5] = '{16'h0010, '{1'b0, 8'hFC, 4'h0, 1'b0, 1'b0}};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_acc = v[k].a;
      @(negedge clock);
      in_valid = 1'b0; in_acc = 'x;
      @(negedge clock);
      n_tests++;
      if (b_valid !== 1'b1 ||
          {b_sign, b_exp, b_frac, b_zero, b_inf} !== {v[k].r.s, v[k].r.e[2:0], v[k].r.f, v[k].r.z, v[k].r.i}) begin
        n_fail++;
        $display("FAIL exp3 acc=%h: got vld=%b fields=%h expected vld=1 fields=%h", v[k].a, b_valid,
                 {b_sign, b_exp, b_frac, b_zero, b_inf}, {v[k].r.s, v[k].r.e[2:0], v[k].r.f, v[k].r.z, v[k].r.i});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[8];
    res_t        x;
    for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k < 8) begin
        in_valid = 1'b1; in_acc = w[k];
      end else begin
        in_valid = 1'b0; in_acc = 'x;
      end
      #1;
      n_tests++;
      if (a_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready cycle %0d: got %b expected 1", k, a_in_ready);
      end
      if (k >= 2) begin
        x = model(w[k-2], 8);
        n_tests++;
        if (a_valid !== 1'b1 || {a_sign, a_exp, a_frac, a_zero, a_inf} !== x) begin
          n_fail++;
          $display("FAIL b2b word %0d acc=%h: got vld=%b fields=%h expected vld=1 fields=%h", k - 2, w[k-2],
                   a_valid, {a_sign, a_exp, a_frac, a_zero, a_inf}, x);
        end
      end
    end
  endtask

  task automatic test_stream();
    res_t q[$];
    res_t x, prev;
    int   sent = 0, cyc = 0, stall = 0;
    bit   stall_done = 1'b0, prev_stalled = 1'b0;
    prev = '0;
    while ((sent < 64 || q.size() > 0) && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (prev_stalled) begin
        n_tests++;
        if (a_valid !== 1'b1 || {a_sign, a_exp, a_frac, a_zero, a_inf} !== prev) begin
          n_fail++;
          $display("FAIL stream_stable cycle %0d: got vld=%b fields=%h expected vld=1 fields=%h", cyc,
                   a_valid, {a_sign, a_exp, a_frac, a_zero, a_inf}, prev);
        end
      end
      if (sent < 64) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: in_acc = 16'($urandom);
          1: in_acc = 16'($urandom_range(0, 31));
          2: in_acc = 16'($urandom) | 16'h0008;
          default: in_acc = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
        endcase
        if (!in_valid) in_acc = 'x;
      end else begin
        in_valid = 1'b0; in_acc = 'x;
      end
      if (stall > 0) begin
        out_ready = 1'b0; stall--;
      end else if (!stall_done && sent >= 32) begin
        out_ready = 1'b0; stall = 4; stall_done = 1'b1;
      end else begin
        out_ready = (sent >= 64) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      if (in_valid && a_in_ready) begin
        q.push_back(model(in_acc, 8));
        sent++;
      end
      if (a_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got unexpected word %h expected none", {a_sign, a_exp, a_frac, a_zero, a_inf});
        end else begin
          x = q.pop_front();
          if ({a_sign, a_exp, a_frac, a_zero, a_inf} !== x) begin
            n_fail++;
            $display("FAIL stream_data cycle %0d: got %h expected %h", cyc, {a_sign, a_exp, a_frac, a_zero, a_inf}, x);
          end
        end
      end
      prev_stalled = a_valid && !out_ready;
      prev = {a_sign, a_exp, a_frac, a_zero, a_inf};
    end
    n_tests++;
    if (sent != 64 || q.size() != 0) begin
      n_fail++; $display("FAIL stream_timeout: got sent=%0d pending=%0d expected 64/0", sent, q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    res_t x;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_valid = 1'b1; in_acc = 16'h0100 + 16'(k);
    end
    @(negedge clock);
    in_valid = 1'b0; in_acc = 'x; resetn = 1'b0;
    @(negedge clock);
    n_tests++;
    if (a_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid: got %b expected 0", a_valid);
    end
    resetn = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_tests++;
      if (a_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_drop cycle %0d: got out_valid=%b expected 0", k, a_valid);
      end
    end
    in_valid = 1'b1; in_acc = 16'hFE60;
    x = model(16'hFE60, 8);
    @(negedge clock);
    in_valid = 1'b0; in_acc = 'x;
    @(negedge clock);
    n_tests++;
    if (a_valid !== 1'b1 || {a_sign, a_exp, a_frac, a_zero, a_inf} !== x) begin
      n_fail++;
      $display("FAIL midreset_recover: got vld=%b fields=%h expected vld=1 fields=%h", a_valid,
               {a_sign, a_exp, a_frac, a_zero, a_inf}, x);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exp3();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
